// File: rtl/i2s_sample_tx_pkg.sv
// Shared frame geometry and FSM encoding for the I2S sample transmitter.
package i2s_sample_tx_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  // Word select is high for these slots; it changes one bit ahead of each MSB.
  localparam logic [SLOT_W-1:0] LR_SLOT_LO = SLOT_W'(15);
  localparam logic [SLOT_W-1:0] LR_SLOT_HI = SLOT_W'(30);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/i2s_sample_tx_if.sv
// Generator-side and codec-side signals of the I2S transmitter, bundled as one port.
interface i2s_sample_tx_if #(
  parameter int SAMPLE_W = i2s_sample_tx_pkg::SAMPLE_W
);

  // Handshake: sampling_pulse is a one-cycle request with no ready/backpressure;
  // new_sample_ready is a one-cycle valid that qualifies sample in that cycle only.
  logic                enable;
  logic [SAMPLE_W-1:0] sample;
  logic                new_sample_ready;
  logic                sampling_pulse;
  logic                bclk;
  logic                lrclk;
  logic                sdata;
  logic                underrun;
  logic                rise_tick;
  logic [0:0]          dbg_state;

  modport master (
    input  enable, sample, new_sample_ready,
    output sampling_pulse, bclk, lrclk, sdata, underrun, rise_tick, dbg_state
  );

  modport slave (
    output enable, sample, new_sample_ready,
    input  sampling_pulse, bclk, lrclk, sdata, underrun, rise_tick, dbg_state
  );

endinterface

// File: rtl/i2s_sample_tx_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV cycles while running, with edge strobes.
module i2s_sample_tx_bclk_gen #(
  parameter int BCLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic bclk_o,
  output logic fall_tick_o,
  output logic rise_tick_o
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  assign term = run_i && (div_q == DIV_LAST);

  always_comb begin
    div_d  = div_q;
    bclk_d = bclk_q;
    if (!run_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (term) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  // Strobes mark the cycle whose closing edge moves bclk.
  assign fall_tick_o = term && bclk_q;
  assign rise_tick_o = term && !bclk_q;
  assign bclk_o      = bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// Paces the sample generator once per frame and shifts each sample out MSB-first on both I2S slots.
module i2s_sample_tx #(
  parameter int BCLK_DIV = 16,
  parameter int SAMPLE_W = i2s_sample_tx_pkg::SAMPLE_W
) (
  input  logic            clk,
  input  logic            reset,
  i2s_sample_tx_if.master bus
);

  import i2s_sample_tx_pkg::*;

  localparam int BIT_W = $clog2(SAMPLE_W);

  logic [0:0]          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SAMPLE_W-1:0] holding_q, holding_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic                fresh_q, fresh_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;

  logic run, fall_tick, rise_tick, bclk;
  logic frame_wrap, frame_start;

  function automatic logic slot_lr(input logic [SLOT_W-1:0] s);
    return (s >= LR_SLOT_LO) && (s <= LR_SLOT_HI);
  endfunction

  function automatic logic [BIT_W-1:0] slot_bit(input logic [SLOT_W-1:0] s);
    return BIT_W'(SAMPLE_W - 1) - s[BIT_W-1:0];
  endfunction

  assign run = (state_q == ST_RUN);

  i2s_sample_tx_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run),
    .bclk_o      (bclk),
    .fall_tick_o (fall_tick),
    .rise_tick_o (rise_tick)
  );

  // A frame starts on leaving IDLE or on the falling edge that closes the last slot;
  // with enable low, that closing edge returns to IDLE instead.
  assign frame_wrap  = fall_tick && (slot_q == SLOT_W'(FRAME_SLOTS - 1));
  assign frame_start = !reset && bus.enable && ((state_q == ST_IDLE) || frame_wrap);

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    holding_d = holding_q;
    fresh_d   = fresh_q;

    if (frame_start) begin
      state_d = ST_RUN;
      slot_d  = '0;
      shift_d = holding_q;
      lrclk_d = slot_lr('0);
      sdata_d = holding_q[SAMPLE_W-1];
      fresh_d = 1'b0;
    end else if (frame_wrap) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
    end else if (fall_tick) begin
      slot_d  = slot_q + SLOT_W'(1);
      lrclk_d = slot_lr(slot_d);
      sdata_d = shift_q[slot_bit(slot_d)];
    end

    // A capture coinciding with a load still leaves a fresh sample behind.
    if (bus.new_sample_ready) begin
      holding_d = bus.sample;
      fresh_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      holding_q <= '0;
      shift_q   <= '0;
      fresh_q   <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      holding_q <= holding_d;
      shift_q   <= shift_d;
      fresh_q   <= fresh_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
    end
  end

  assign bus.sampling_pulse = frame_start;
  assign bus.underrun       = frame_start && !fresh_q;
  assign bus.bclk           = bclk;
  assign bus.lrclk          = lrclk_q;
  assign bus.sdata          = sdata_q;
  assign bus.rise_tick      = rise_tick;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: frame-level reference model of the I2S stream as seen by the DAC.
module tb_i2s_sample_tx;

  localparam int D         = 2;
  localparam int FRAME_CYC = 64 * D;

  logic clk;
  logic reset;

  i2s_sample_tx_if #(.SAMPLE_W(16)) bus ();

  i2s_sample_tx #(
    .BCLK_DIV (D),
    .SAMPLE_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the holding word and whether it is new since the last frame start.
  logic [15:0] model_holding;
  logic        model_fresh;
  logic [16:0] exp_q[$];   // {expected underrun, expected word} per frame

  function automatic logic [31:0] lr_rule();
    logic [31:0] v;
    v = '0;
    for (int s = 0; s < 32; s++) v[31-s] = (s >= 15) && (s <= 30);
    return v;
  endfunction

  // Runs n_cyc cycles starting at the start of a frame-start cycle; observes what the DAC sees.
  task automatic run_frame(input int resp_k, input logic [15:0] value, input int drop_k,
                           input int n_cyc, output logic [31:0] bits, output logic [31:0] lr,
                           output int pulses, output int unds, output int rises,
                           output int gap_min, output int gap_max, output logic pulse0);
    int   last;
    logic prev;
    bits = '0; lr = '0; pulses = 0; unds = 0; rises = 0;
    gap_min = 1 << 30; gap_max = 0; last = -1; prev = 1'b0; pulse0 = 1'b0;
    for (int k = 0; k < n_cyc; k++) begin
      bus.enable           = (drop_k < 0) || (k < drop_k);
      bus.new_sample_ready = (k == resp_k);
      bus.sample           = (k == resp_k) ? value : 16'($urandom);
      if (k == 0) begin
        exp_q.push_back({!model_fresh, model_holding});
        model_fresh = 1'b0;
      end
      if (k == resp_k) begin
        model_holding = value;
        model_fresh   = 1'b1;
      end
      @(negedge clk);
      if (k == 0) pulse0 = bus.sampling_pulse;
      pulses += int'(bus.sampling_pulse);
      unds   += int'(bus.underrun);
      if (k > 0 && bus.bclk && !prev) begin
        if (rises < 32) begin
          bits[31-rises] = bus.sdata;
          lr[31-rises]   = bus.lrclk;
        end
        if (last >= 0) begin
          if (k - last < gap_min) gap_min = k - last;
          if (k - last > gap_max) gap_max = k - last;
        end
        last = k;
        rises++;
      end
      prev = bus.bclk;
      @(posedge clk); #1;
    end
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.sampling_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", bus.sampling_pulse); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", bus.underrun); end
    checks++; if (bus.bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk: got %b want 0", bus.bclk); end
    checks++; if (bus.lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b want 0", bus.lrclk); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata: got %b want 0", bus.sdata); end
    checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", bus.dbg_state); end
    @(posedge clk); #1;
    bus.enable = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    checks++; if (bus.sampling_pulse !== 1'b0) begin errors++; $display("FAIL idle_pulse: got %b want 0", bus.sampling_pulse); end
    @(posedge clk); #1;
  endtask

  task automatic test_first_frame();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    run_frame(1, 16'h8001, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL first_pulse: got %b want 1", p0); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL first_pulse_count: got %0d want 1", pulses); end
    checks++; if (rises != 32) begin errors++; $display("FAIL first_bclk_rises: got %0d want 32", rises); end
    checks++; if (gmin != 2 * D || gmax != 2 * D) begin errors++; $display("FAIL bclk_period: got %0d..%0d want %0d", gmin, gmax, 2 * D); end
    checks++; if (lr !== lr_rule()) begin errors++; $display("FAIL lrclk_slots: got %h want %h", lr, lr_rule()); end
    checks++; if (bits !== {e[15:0], e[15:0]}) begin errors++; $display("FAIL first_data: got %h want %h", bits, {e[15:0], e[15:0]}); end
    checks++; if (unds != int'(e[16])) begin errors++; $display("FAIL first_underrun: got %0d want %0d", unds, e[16]); end
  endtask

  task automatic test_pattern();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    run_frame(1, 16'h8001, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== 32'h8001_8001) begin errors++; $display("FAIL pattern_data: got %h want 80018001", bits); end
    checks++; if (unds != 0 || e[16] !== 1'b0) begin errors++; $display("FAIL pattern_underrun: got %0d want 0", unds); end
    checks++; if (lr !== lr_rule()) begin errors++; $display("FAIL pattern_lrclk: got %h want %h", lr, lr_rule()); end
  endtask

  task automatic test_underrun();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    run_frame(-1, 16'h0000, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== {e[15:0], e[15:0]}) begin errors++; $display("FAIL withheld_data: got %h want %h", bits, {e[15:0], e[15:0]}); end
    checks++; if (unds != int'(e[16])) begin errors++; $display("FAIL withheld_underrun: got %0d want %0d", unds, e[16]); end
    run_frame(1, 16'hABCD, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== 32'h8001_8001) begin errors++; $display("FAIL repeat_data: got %h want 80018001", bits); end
    checks++; if (unds != 1) begin errors++; $display("FAIL repeat_underrun: got %0d want 1", unds); end
    checks++; if (e[16] !== 1'b1) begin errors++; $display("FAIL repeat_model: got %b want 1", e[16]); end
  endtask

  task automatic test_coincident();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    run_frame(0, 16'h1234, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== 32'hABCD_ABCD) begin errors++; $display("FAIL coincide_old_data: got %h want abcdabcd", bits); end
    checks++; if (unds != int'(e[16])) begin errors++; $display("FAIL coincide_underrun: got %0d want %0d", unds, e[16]); end
    run_frame(1, 16'($urandom), -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== 32'h1234_1234) begin errors++; $display("FAIL coincide_new_data: got %h want 12341234", bits); end
    checks++; if (unds != 0) begin errors++; $display("FAIL coincide_next_underrun: got %0d want 0", unds); end
  endtask

  task automatic test_random();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    int resp_k;
    for (int f = 0; f < 6; f++) begin
      resp_k = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, FRAME_CYC - 1)) : -1;
      run_frame(resp_k, 16'($urandom), -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
      e = exp_q.pop_front();
      checks++; if (bits !== {e[15:0], e[15:0]}) begin errors++; $display("FAIL random_data[%0d]: got %h want %h", f, bits, {e[15:0], e[15:0]}); end
      checks++; if (unds != int'(e[16]) || pulses != 1) begin errors++; $display("FAIL random_underrun[%0d]: got und=%0d pulses=%0d want und=%0d pulses=1", f, unds, pulses, e[16]); end
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    run_frame(1, 16'hC3A5, 30, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (rises != 32) begin errors++; $display("FAIL drop_rises: got %0d want 32", rises); end
    checks++; if (bits !== {e[15:0], e[15:0]}) begin errors++; $display("FAIL drop_data: got %h want %h", bits, {e[15:0], e[15:0]}); end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++; if (bus.sampling_pulse !== 1'b0) begin errors++; $display("FAIL drop_no_pulse[%0d]: got %b want 0", j, bus.sampling_pulse); end
      if (j >= 1) begin
        checks++;
        if ({bus.bclk, bus.lrclk, bus.sdata} !== 3'b000) begin
          errors++; $display("FAIL drop_idle_outputs[%0d]: got %b want 000", j, {bus.bclk, bus.lrclk, bus.sdata});
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL drop_state: got %b want 0", bus.dbg_state); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bits, lr; int pulses, unds, rises, gmin, gmax; logic p0; logic [16:0] e;
    // Stop inside slot 20, where word select is high.
    run_frame(1, 16'h7E81, -1, 40 * D + 2, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bus.lrclk !== 1'b1) begin errors++; $display("FAIL mid_lrclk_before: got %b want 1", bus.lrclk); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.lrclk !== 1'b0) begin errors++; $display("FAIL mid_reset_lrclk: got %b want 0", bus.lrclk); end
    checks++; if (bus.bclk !== 1'b0) begin errors++; $display("FAIL mid_reset_bclk: got %b want 0", bus.bclk); end
    checks++; if (bus.sdata !== 1'b0) begin errors++; $display("FAIL mid_reset_sdata: got %b want 0", bus.sdata); end
    checks++; if (bus.sampling_pulse !== 1'b0 || bus.underrun !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses: got %b%b want 00", bus.sampling_pulse, bus.underrun); end
    model_holding = 16'h0000;
    model_fresh   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(1, 16'h5A5A, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL restart_pulse: got %b want 1", p0); end
    checks++; if (bits !== 32'h0 || bits !== {e[15:0], e[15:0]}) begin errors++; $display("FAIL restart_data: got %h want 00000000", bits); end
    checks++; if (unds != 1) begin errors++; $display("FAIL restart_underrun: got %0d want 1", unds); end
    checks++; if (lr !== lr_rule()) begin errors++; $display("FAIL restart_lrclk: got %h want %h", lr, lr_rule()); end
    run_frame(1, 16'h0F0F, -1, FRAME_CYC, bits, lr, pulses, unds, rises, gmin, gmax, p0);
    e = exp_q.pop_front();
    checks++; if (bits !== 32'h5A5A_5A5A) begin errors++; $display("FAIL restart_next_data: got %h want 5a5a5a5a", bits); end
  endtask

  initial begin
    reset                = 1'b1;
    bus.enable           = 1'b0;
    bus.new_sample_ready = 1'b0;
    bus.sample           = '0;
    model_holding        = 16'h0000;
    model_fresh          = 1'b0;
    test_reset();
    test_first_frame();
    test_pattern();
    test_underrun();
    test_coincident();
    test_random();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
